ase_rsp_reorder_buffer: RTL and testbench

- Receive-side companion to the out-of-order latency channel.
- Issues sequential tags to outgoing requests and accepts tagged responses in any order.
- Releases responses strictly in allocation order over a valid/ready interface.
- Sits between the ASE response path and an in-order consumer, such as an AFU read port or a checker.

---
 rtl/ase_rsp_reorder_buffer.sv | 117 +++++++++++
 tb/tb_ase_rsp_reorder_buffer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ase_rsp_reorder_buffer.sv
// Response reorder buffer: hands out sequential tags, captures tagged responses
// in any order and releases them to the consumer strictly in allocation order.
module ase_rsp_reorder_buffer #(
    parameter int NUM_TAGS   = 16,
    parameter int TAG_WIDTH  = 4,
    parameter int HDR_WIDTH  = 80,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    output logic                  alloc_gnt,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    input  logic                  rsp_valid,
    input  logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic [HDR_WIDTH-1:0]  rsp_hdr,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [HDR_WIDTH-1:0]  out_hdr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH:0]    outstanding,
    output logic                  full,
    output logic                  empty,
    output logic                  err_unalloc,
    output logic                  err_dup
);

    localparam logic [TAG_WIDTH:0] FULL_CNT = (TAG_WIDTH + 1)'(NUM_TAGS);
    localparam logic [TAG_WIDTH:0] PTR_ONE  = (TAG_WIDTH + 1)'(1);

    logic [TAG_WIDTH:0]    head_q, head_d;
    logic [TAG_WIDTH:0]    tail_q, tail_d;
    logic [NUM_TAGS-1:0]   filled_q, filled_d;
    logic                  err_unalloc_q, err_unalloc_d;
    logic                  err_dup_q, err_dup_d;
    logic [HDR_WIDTH-1:0]  hdr_mem_q [NUM_TAGS];
    logic [DATA_WIDTH-1:0] data_mem_q [NUM_TAGS];

    logic [TAG_WIDTH-1:0]  head_idx;
    logic [TAG_WIDTH-1:0]  rsp_rel;
    logic                  in_flight;
    logic                  rsp_accept;
    logic                  pop;

    assign head_idx    = head_q[TAG_WIDTH-1:0];
    assign outstanding = tail_q - head_q;
    assign full        = (outstanding == FULL_CNT);
    assign empty       = (outstanding == '0);

    assign alloc_gnt   = alloc_req & ~full & ~rst;
    assign alloc_tag   = tail_q[TAG_WIDTH-1:0];

    assign out_valid   = ~empty & filled_q[head_idx];
    assign out_hdr     = hdr_mem_q[head_idx];
    assign out_data    = data_mem_q[head_idx];
    assign pop         = out_valid & out_ready;

    // Distance from head decides in-flight; uses pre-edge occupancy, so a tag
    // allocated this same cycle is not yet in flight.
    assign rsp_rel     = rsp_tag - head_idx;
    assign in_flight   = ({1'b0, rsp_rel} < outstanding);
    assign rsp_accept  = rsp_valid & in_flight & ~filled_q[rsp_tag];

    assign err_unalloc = err_unalloc_q;
    assign err_dup     = err_dup_q;

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        filled_d      = filled_q;
        err_unalloc_d = err_unalloc_q;
        err_dup_d     = err_dup_q;

        if (alloc_gnt) begin
            tail_d = tail_q + PTR_ONE;
        end
        if (pop) begin
            head_d             = head_q + PTR_ONE;
            filled_d[head_idx] = 1'b0;
        end
        // An accepted slot is never the popped slot: accept needs filled=0, pop needs filled=1.
        if (rsp_accept) begin
            filled_d[rsp_tag] = 1'b1;
        end
        if (rsp_valid & ~in_flight) begin
            err_unalloc_d = 1'b1;
        end
        if (rsp_valid & in_flight & filled_q[rsp_tag]) begin
            err_dup_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            filled_q      <= '0;
            err_unalloc_q <= 1'b0;
            err_dup_q     <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            filled_q      <= filled_d;
            err_unalloc_q <= err_unalloc_d;
            err_dup_q     <= err_dup_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_accept) begin
            hdr_mem_q[rsp_tag]  <= rsp_hdr;
            data_mem_q[rsp_tag] <= rsp_data;
        end
    end

endmodule

// File: tb/tb_ase_rsp_reorder_buffer.sv
// Bench for ase_rsp_reorder_buffer: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_ase_rsp_reorder_buffer;

    localparam int NT = 16;
    localparam int TW = 4;
    localparam int HW = 80;
    localparam int DW = 64;
    localparam logic [63:0] BASE = 64'hCAFEBABE_BEBAFEC0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_req = 1'b0;
    logic          alloc_gnt;
    logic [TW-1:0] alloc_tag;
    logic          rsp_valid = 1'b0;
    logic [TW-1:0] rsp_tag = '0;
    logic [HW-1:0] rsp_hdr = '0;
    logic [DW-1:0] rsp_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [HW-1:0] out_hdr;
    logic [DW-1:0] out_data;
    logic [TW:0]   outstanding;
    logic          full;
    logic          empty;
    logic          err_unalloc;
    logic          err_dup;

    int checks = 0;
    int errors = 0;

    ase_rsp_reorder_buffer #(
        .NUM_TAGS(NT), .TAG_WIDTH(TW), .HDR_WIDTH(HW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_hdr(rsp_hdr), .rsp_data(rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_hdr(out_hdr), .out_data(out_data),
        .outstanding(outstanding), .full(full), .empty(empty),
        .err_unalloc(err_unalloc), .err_dup(err_dup)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight tags kept as an allocation-ordered queue.
    int unsigned   m_q[$];
    bit            m_got[NT];
    logic [HW-1:0] m_hdr[NT];
    logic [DW-1:0] m_data[NT];
    int            m_next = 0;
    bit            m_eu = 0;
    bit            m_ed = 0;
    logic [DW-1:0] pop_log[$];

    function automatic bit m_valid();
        return (m_q.size() > 0) && m_got[m_q[0]];
    endfunction

    always @(posedge clk) begin
        bit gnt, pop, infl;
        int t;
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < NT; i++) m_got[i] = 0;
            m_next = 0;
            m_eu = 0;
            m_ed = 0;
        end else begin
            gnt = alloc_req && (m_q.size() < NT);
            pop = m_valid() && out_ready;
            if (rsp_valid) begin
                t = int'(rsp_tag);
                infl = 0;
                foreach (m_q[i]) if (m_q[i] == t) infl = 1;
                if (!infl) m_eu = 1;
                else if (m_got[t]) m_ed = 1;
                else begin
                    m_got[t] = 1;
                    m_hdr[t] = rsp_hdr;
                    m_data[t] = rsp_data;
                end
            end
            if (pop) begin
                m_got[m_q[0]] = 0;
                void'(m_q.pop_front());
            end
            if (gnt) begin
                m_q.push_back(m_next);
                m_next = (m_next + 1) % NT;
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = m_valid();
        check("alloc_gnt", 128'(alloc_gnt), 128'(!rst && alloc_req && (m_q.size() < NT)));
        check("alloc_tag", 128'(alloc_tag), 128'(m_next));
        check("outstanding", 128'(outstanding), 128'(m_q.size()));
        check("full", 128'(full), 128'(m_q.size() == NT));
        check("empty", 128'(empty), 128'(m_q.size() == 0));
        check("out_valid", 128'(out_valid), 128'(ev));
        check("err_unalloc", 128'(err_unalloc), 128'(m_eu));
        check("err_dup", 128'(err_dup), 128'(m_ed));
        if (ev) begin
            check("out_hdr", 128'(out_hdr), 128'(m_hdr[m_q[0]]));
            check("out_data", 128'(out_data), 128'(m_data[m_q[0]]));
        end
        if (!rst && out_valid && out_ready) pop_log.push_back(out_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_req = 1'b0;
        rsp_valid = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        pop_log.delete();
    endtask

    function automatic logic [HW-1:0] hdr_of(input int k);
        return {16'hA5A5, 64'(k) ^ 64'h0000_FFFF_0000_FFFF};
    endfunction

    task automatic send(input int tag, input logic [DW-1:0] d);
        rsp_valid = 1'b1;
        rsp_tag = TW'(tag);
        rsp_hdr = hdr_of(tag);
        rsp_data = d;
        step();
        rsp_valid = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        alloc_req = 1'b1;
        repeat (n) step();
        alloc_req = 1'b0;
    endtask

    initial begin
        int perm[8];
        int j, tmp, k;

        step();
        check("rst_outstanding", 128'(outstanding), 128'(0));
        check("rst_empty", 128'(empty), 128'(1));
        check("rst_alloc_tag", 128'(alloc_tag), 128'(0));
        do_reset();

        // In-order responses
        out_ready = 1'b1;
        alloc_n(4);
        for (int t = 0; t < 4; t++) send(t, BASE + 64'(t));
        repeat (4) step();
        check("inorder_pops", 128'(pop_log.size()), 128'(4));
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("inorder_data", 128'(pop_log[i]), 128'(BASE + 64'(i)));
        check("inorder_empty", 128'(empty), 128'(1));
        check("inorder_outstanding", 128'(outstanding), 128'(0));

        // Reverse-order responses
        do_reset();
        out_ready = 1'b1;
        alloc_n(4);
        for (int t = 3; t >= 1; t--) begin
            send(t, BASE + 64'(t));
            check("reverse_hold", 128'(out_valid), 128'(0));
        end
        rsp_valid = 1'b1; rsp_tag = '0; rsp_hdr = hdr_of(0); rsp_data = BASE;
        #1;
        check("reverse_no_bypass", 128'(out_valid), 128'(0));
        step();
        rsp_valid = 1'b0;
        check("reverse_visible", 128'(out_valid), 128'(1));
        repeat (4) step();
        check("reverse_pops", 128'(pop_log.size()), 128'(4));
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("reverse_data", 128'(pop_log[i]), 128'(BASE + 64'(i)));

        // Full and backpressure
        do_reset();
        alloc_req = 1'b1;
        repeat (16) step();
        check("full_set", 128'(full), 128'(1));
        check("full_no_gnt", 128'(alloc_gnt), 128'(0));
        for (int i = 0; i < 16; i++) send((i * 5) % 16, BASE + 64'((i * 5) % 16));
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 128'(out_valid), 128'(1));
            check("bp_data", 128'(out_data), 128'(BASE));
            step();
        end
        out_ready = 1'b1;
        check("pop_no_bypass_gnt", 128'(alloc_gnt), 128'(0));
        step();
        check("full_clear", 128'(full), 128'(0));
        check("gnt_returns", 128'(alloc_gnt), 128'(1));
        repeat (20) step();
        alloc_req = 1'b0;
        step();
        check("full_pops", 128'(pop_log.size()), 128'(16));
        for (int i = 0; i < 16 && i < pop_log.size(); i++)
            check("full_data", 128'(pop_log[i]), 128'(BASE + 64'(i)));

        // Wrap-around: 40 rounds, shuffled within windows of 8
        do_reset();
        for (int w = 0; w < 5; w++) begin
            out_ready = 1'b1;
            alloc_n(8);
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            for (int i = 0; i < 8; i++) begin
                k = 8 * w + perm[i];
                out_ready = 1'($urandom_range(1, 0));
                send(k % 16, BASE + 64'(k));
            end
            out_ready = 1'b1;
            repeat (10) step();
        end
        check("wrap_pops", 128'(pop_log.size()), 128'(40));
        for (int i = 0; i < 40 && i < pop_log.size(); i++)
            check("wrap_data", 128'(pop_log[i]), 128'(BASE + 64'(i)));
        check("wrap_no_unalloc", 128'(err_unalloc), 128'(0));
        check("wrap_no_dup", 128'(err_dup), 128'(0));

        // Error flags
        do_reset();
        alloc_n(2);
        send(5, 64'h5555);
        check("unalloc_set", 128'(err_unalloc), 128'(1));
        check("unalloc_no_dup", 128'(err_dup), 128'(0));
        check("unalloc_no_fill", 128'(out_valid), 128'(0));
        send(1, 64'h1111_0001);
        check("dup_clear", 128'(err_dup), 128'(0));
        send(1, 64'h2222_0002);
        check("dup_set", 128'(err_dup), 128'(1));
        send(0, 64'h0000_0A0A);
        out_ready = 1'b1;
        repeat (3) step();
        check("err_pops", 128'(pop_log.size()), 128'(2));
        if (pop_log.size() == 2) begin
            check("err_data0", 128'(pop_log[0]), 128'(64'h0000_0A0A));
            check("err_dup_kept", 128'(pop_log[1]), 128'(64'h1111_0001));
        end

        // Reset mid-operation
        do_reset();
        alloc_n(6);
        send(1, BASE + 1);
        send(2, BASE + 2);
        send(3, BASE + 3);
        send(12, BASE);
        check("mid_outstanding", 128'(outstanding), 128'(6));
        check("mid_unalloc", 128'(err_unalloc), 128'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_outstanding", 128'(outstanding), 128'(0));
        check("mrst_empty", 128'(empty), 128'(1));
        check("mrst_valid", 128'(out_valid), 128'(0));
        check("mrst_unalloc", 128'(err_unalloc), 128'(0));
        check("mrst_tag", 128'(alloc_tag), 128'(0));
        // Response to the tag being allocated in the same cycle is not in flight
        alloc_req = 1'b1;
        send(0, BASE);
        alloc_req = 1'b0;
        check("same_cycle_unalloc", 128'(err_unalloc), 128'(1));
        check("same_cycle_outstanding", 128'(outstanding), 128'(1));
        pop_log.delete();
        send(0, BASE + 64'h77);
        out_ready = 1'b1;
        repeat (2) step();
        check("mrst_pops", 128'(pop_log.size()), 128'(1));
        if (pop_log.size() == 1) check("mrst_data", 128'(pop_log[0]), 128'(BASE + 64'h77));

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
